pdm_decoder: RTL and testbench
==============================

// Module: pdm_decoder
// PURPOSE
// - Receive-side counterpart of the 1-bit PDM DAC: recovers signed PCM samples from a PDM bitstream.
// - 2nd-order CIC integrator/comb filter with decimation by 2**DECIM_LOG2; bit density maps back to
//   the DAC's offset-binary convention (density d -> pcm = d*2**OUTPUT_BITS - 2**(OUTPUT_BITS-1)).
// - Used for on-chip loopback/self-test of the synth output path and for scoring the PDM stream in sim.
// PARAMETERS
// - OUTPUT_BITS  12  width of signed PCM output
// - DECIM_LOG2   6   log2 of decimation ratio R (R=64); must satisfy 2*DECIM_LOG2 >= OUTPUT_BITS
// PORTS
// - clk        in   1            system clock; one PDM bit per enabled cycle
// - rst        in   1            synchronous, active-high reset
// - enable     in   1            1 = sample pdm_in this cycle; 0 = freeze all state
// - pdm_in     in   1            PDM bitstream (1 = +full scale, 0 = -full scale)
// - pcm_out    out  OUTPUT_BITS  signed decoded sample, held between updates
// - pcm_valid  out  1            one-cycle strobe: pcm_out updated this cycle
// - overload   out  1            valid with pcm_valid: this sample was saturated
// BEHAVIOUR
// - Clock/reset: one clock (clk); reset synchronous, active-high (rst). Reset clears integrators,
//   comb delays, decimation counter, warm-up counter; pcm_out=0, pcm_valid=0, overload=0.
// - Internal width W = 2*DECIM_LOG2+1 (13). Integrators/combs are modular W-bit: wrap, never saturate.
// - Integrators (enable=1 only): i1 <= i1 + pdm_in; i2 <= i2 + i1 (old i1).
// - Decimation counter dc: 0..R-1, increments on enable, wraps R-1 -> 0.
// - Decimation event = enable && dc==R-1: c1 = i2 - i2_d; c2 = c1 - c1_d; i2_d <= i2; c1_d <= c1.
// - Output stage (registered, cycle after event): s = c2 >> (2*DECIM_LOG2-OUTPUT_BITS) (unsigned);
//   v = s - 2**(OUTPUT_BITS-1); pcm_out = clamp(v, -2**(OB-1), 2**(OB-1)-1); overload=1 iff clamped.
// - Warm-up: first 2 decimation events after reset update comb delays only; pcm_valid/pcm_out/
//   overload not updated. 3rd and later events produce output.
// - Latency: pcm_valid asserts 1 cycle after the decimation event. With enable held 1 from reset
//   release (cycle 0 = first enabled cycle), first pcm_valid at cycle 3R (192), then every R cycles.
// - enable=0: i1,i2,dc,comb state, warm-up count frozen; pcm_valid=0; pcm_out holds. Stream resumes
//   exactly as if disabled cycles were removed.
// - Event coinciding with rst: rst wins; no pcm_valid is produced.
// - Reset mid-frame: partial frame discarded; warm-up restarts (2 events suppressed again).
// - overload only meaningful when pcm_valid=1; 0 otherwise.
// - Steady state (R=64, OB=12): all-ones -> s=4096 -> pcm 2047, overload=1; all-zeros -> -2048,
//   overload=0; 50% density -> 0.
// TESTING
// - Reset, enable=1, pdm_in=1 constant -> first pcm_valid at cycle 192; pcm_out=2047, overload=1
//   on every strobe; strobes exactly 64 cycles apart.
// - pdm_in=0 constant -> pcm_out=-2048 (0x800), overload=0 from 3rd event onward.
// - pdm_in alternating 1,0,1,0 -> pcm_out=0 every valid sample.
// - Loopback: DAC driven with din=+1024 -> decoder pcm_out within 1024 +/-2 after warm-up;
//   din=-1536 -> -1536 +/-2; din step mid-run -> settles within 2 output samples.
// - enable toggled 1-of-3 cycles with 50% stream -> first pcm_valid after 192 enabled cycles,
//   pcm_out=0; no strobe on any enable=0 cycle.
// - rst pulsed at dc=30 mid-run -> outputs 0 next cycle; next pcm_valid 192 enabled cycles later.

Source files
------------

// File: rtl/pdm_decoder.sv
// -----------------------------------------------------------------------------
// pdm_decoder
//
// Recovers signed PCM samples from a 1-bit PDM stream. This is the receive-side
// counterpart of the PDM DAC. It is used for on-chip loopback and self-test of
// the synth output path.
//
// Structure
//   - Second-order CIC filter: two integrators, then two combs at the
//     decimated rate.
//   - Decimation by R = 2**DECIM_LOG2.
//   - The bit density d maps back to the DAC's offset-binary convention:
//     pcm = d * 2**OUTPUT_BITS - 2**(OUTPUT_BITS-1), saturated to OUTPUT_BITS.
//
// Parameters
//   OUTPUT_BITS  width of the signed PCM output (default 12)
//   DECIM_LOG2   log2 of the decimation ratio (default 6, R = 64).
//                Requires 2*DECIM_LOG2 >= OUTPUT_BITS.
//
// Ports
//   clk        system clock; one PDM bit per enabled cycle
//   rst        synchronous, active-high reset
//   enable     1 = consume pdm_in this cycle; 0 = freeze all state
//   pdm_in     PDM bit (1 = +full scale, 0 = -full scale)
//   pcm_out    signed decoded sample, held between updates
//   pcm_valid  one-cycle strobe: pcm_out carries a new sample this cycle
//   overload   qualified by pcm_valid: this sample was saturated
// -----------------------------------------------------------------------------
module pdm_decoder #(
    parameter int OUTPUT_BITS = 12,
    parameter int DECIM_LOG2  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   pdm_in,
    output logic [OUTPUT_BITS-1:0] pcm_out,
    output logic                   pcm_valid,
    output logic                   overload
);

    // Internal CIC width.
    // The full-scale comb output is R**2 = 2**(2*DECIM_LOG2), so one extra
    // bit is enough. The integrators and combs are allowed to wrap: modular
    // arithmetic makes the comb differences exact anyway.
    localparam int W     = 2*DECIM_LOG2 + 1;
    localparam int SHIFT = 2*DECIM_LOG2 - OUTPUT_BITS;

    localparam logic signed [W:0] OFFSET  = (W+1)'(2**(OUTPUT_BITS-1));
    localparam logic signed [W:0] PCM_MAX = OFFSET - (W+1)'(1);
    localparam logic signed [W:0] PCM_MIN = -OFFSET;

    // Saturate the re-centred sample into the OUTPUT_BITS range.
    function automatic logic [OUTPUT_BITS-1:0] sat_pcm(input logic signed [W:0] v);
        if (v > PCM_MAX)
            return PCM_MAX[OUTPUT_BITS-1:0];
        else if (v < PCM_MIN)
            return PCM_MIN[OUTPUT_BITS-1:0];
        else
            return v[OUTPUT_BITS-1:0];
    endfunction

    // Flag a sample that sat_pcm had to clamp.
    function automatic logic is_clamped(input logic signed [W:0] v);
        return (v > PCM_MAX) || (v < PCM_MIN);
    endfunction

    // Integrator state, decimation counter and comb delays
    logic [W-1:0]            i1;
    logic [W-1:0]            i2;
    logic [W-1:0]            i2_d;
    logic [W-1:0]            c1_d;
    logic [DECIM_LOG2-1:0]   dc;
    logic [1:0]              warm;

    // Output stage registers
    logic [OUTPUT_BITS-1:0]  pcm_new_p1;
    logic                    ovl_p1;
    logic                    vld_p1;
    logic [OUTPUT_BITS-1:0]  pcm_hold_p2;

    // ---- stage p0: decimation event, comb section and rescale (combinational)
    logic                    event_p0;
    logic [W-1:0]            c1_p0;
    logic [W-1:0]            c2_p0;
    logic [W-1:0]            s_p0;
    logic signed [W:0]       v_p0;

    assign event_p0 = enable && (&dc);
    assign c1_p0    = i2 - i2_d;
    assign c2_p0    = c1_p0 - c1_d;
    // c2 is an unsigned magnitude: full-scale all-ones gives exactly 2**(W-1).
    assign s_p0     = c2_p0 >> SHIFT;
    assign v_p0     = $signed({1'b0, s_p0}) - OFFSET;

    always_ff @(posedge clk) begin
        if (rst) begin
            i1          <= '0;
            i2          <= '0;
            i2_d        <= '0;
            c1_d        <= '0;
            dc          <= '0;
            warm        <= '0;
            pcm_new_p1  <= '0;
            ovl_p1      <= 1'b0;
            vld_p1      <= 1'b0;
            pcm_hold_p2 <= '0;
        end else begin
            if (enable) begin
                i1 <= i1 + {{(W-1){1'b0}}, pdm_in};
                i2 <= i2 + i1;
                dc <= dc + DECIM_LOG2'(1);
            end

            if (event_p0) begin
                i2_d <= i2;
                c1_d <= c1_p0;
                // The first two events only prime the comb delays.
                if (warm != 2'd2)
                    warm <= warm + 2'd1;
            end

            // ---- stage p1: captured sample, pending until the next enabled cycle
            if (event_p0 && warm == 2'd2) begin
                pcm_new_p1 <= sat_pcm(v_p0);
                ovl_p1     <= is_clamped(v_p0);
                vld_p1     <= 1'b1;
            end else if (enable) begin
                vld_p1     <= 1'b0;
            end

            // ---- stage p2: value held on pcm_out between strobes
            if (pcm_valid)
                pcm_hold_p2 <= pcm_new_p1;
        end
    end

    // A sample produced on the last enabled cycle of a frame is presented on
    // the next enabled cycle. Disabled cycles therefore show neither a strobe
    // nor a changed pcm_out, and the stream behaves as if those cycles were
    // removed.
    assign pcm_valid = vld_p1 && enable;
    assign pcm_out   = pcm_valid ? pcm_new_p1 : pcm_hold_p2;
    assign overload  = ovl_p1 && pcm_valid;

endmodule

// File: tb/tb_pdm_decoder.sv
module tb_pdm_decoder;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        pdm_in;
    logic [11:0] pcm_out;
    logic        pcm_valid;
    logic        overload;

    pdm_decoder #(
        .OUTPUT_BITS (12),
        .DECIM_LOG2  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .overload  (overload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Outputs sampled in the current cycle
    logic        s_valid;
    logic        s_ovl;
    int          s_pcm;

    // Results collected by run_stream
    int          first_idx;
    int          n_strb;
    int          bad_gap;
    int          spurious;
    int          hold_bad;
    int          strb_pcm [4];
    int          strb_ovl [4];

    typedef struct {
        int mode;      // bit pattern, see pat()
        int period;    // enable asserted 1 of every `period` cycles
        int exp_pcm;
        int exp_ovl;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs away from the active edge, then sample outputs.
    task automatic cyc(input logic r, input logic en, input logic b);
        @(negedge clk);
        rst    = r;
        enable = en;
        pdm_in = b;
        #1;
        s_valid = pcm_valid;
        s_ovl   = overload;
        s_pcm   = int'($signed(pcm_out));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Bit patterns indexed by enabled-cycle count k
    function automatic logic pat(input int mode, input int k);
        case (mode)
            0: return 1'b1;                // all ones, density 1
            1: return 1'b0;                // all zeros, density 0
            2: return (k % 2) == 0;        // 1,0,1,0, density 1/2
            3: return (k % 4) == 0;        // density 1/4
            4: return (k % 4) != 0;        // density 3/4
            5: return (k % 8) == 0;        // density 1/8
            default: return 1'b0;
        endcase
    endfunction

    // Feed n_en enabled cycles of a pattern. Record the strobe positions in
    // enabled-cycle units and the strobe values. Count strobes on disabled
    // cycles, overload without valid, and pcm_out changes without a strobe.
    task automatic run_stream(input int mode, input int period, input int n_en,
                              input int held0);
        int k;
        int c;
        int prev;
        int held;
        logic en;
        k = 0; c = 0; prev = -1; held = held0;
        first_idx = -1; n_strb = 0; bad_gap = 0; spurious = 0; hold_bad = 0;
        while (k < n_en) begin
            en = ((c % period) == 0);
            cyc(1'b0, en, pat(mode, k));
            if (s_valid) begin
                if (!en) spurious++;
                if (first_idx < 0) first_idx = k;
                if (prev >= 0 && (k - prev) != 64) bad_gap++;
                if (n_strb < 4) begin
                    strb_pcm[n_strb] = s_pcm;
                    strb_ovl[n_strb] = int'(s_ovl);
                end
                n_strb++;
                prev = k;
                held = s_pcm;
            end else begin
                if (s_pcm != held) hold_bad++;
                if (s_ovl) spurious++;
            end
            if (en) k++;
            c++;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pdm_in = 1'b0;

        vecs[0] = '{mode: 0, period: 1, exp_pcm:  2047, exp_ovl: 1};
        vecs[1] = '{mode: 1, period: 1, exp_pcm: -2048, exp_ovl: 0};
        vecs[2] = '{mode: 2, period: 1, exp_pcm:     0, exp_ovl: 0};
        vecs[3] = '{mode: 3, period: 1, exp_pcm: -1024, exp_ovl: 0};
        vecs[4] = '{mode: 4, period: 1, exp_pcm:  1024, exp_ovl: 0};
        vecs[5] = '{mode: 5, period: 1, exp_pcm: -1536, exp_ovl: 0};
        vecs[6] = '{mode: 2, period: 3, exp_pcm:     0, exp_ovl: 0};
        vecs[7] = '{mode: 0, period: 3, exp_pcm:  2047, exp_ovl: 1};

        // Reset state
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        chk("reset_pcm", s_pcm, 0);
        chk("reset_valid", int'(s_valid), 0);
        chk("reset_ovl", int'(s_ovl), 0);

        // Table-driven streams: three strobes each, first at enabled index 192
        for (int v = 0; v < 8; v++) begin
            do_reset();
            run_stream(vecs[v].mode, vecs[v].period, 192 + 2*64 + 1, 0);
            chk($sformatf("v%0d_first_idx", v), first_idx, 192);
            chk($sformatf("v%0d_n_strobes", v), n_strb, 3);
            chk($sformatf("v%0d_gap", v), bad_gap, 0);
            chk($sformatf("v%0d_spurious", v), spurious, 0);
            chk($sformatf("v%0d_hold", v), hold_bad, 0);
            for (int s = 0; s < 3; s++) begin
                chk($sformatf("v%0d_pcm%0d", v, s), strb_pcm[s], vecs[v].exp_pcm);
                chk($sformatf("v%0d_ovl%0d", v, s), strb_ovl[s], vecs[v].exp_ovl);
            end
        end

        // Reset mid-frame at dc=30: partial frame dropped, warm-up restarts
        do_reset();
        run_stream(0, 1, 256 + 30, 0);
        chk("midrst_pre_strobes", n_strb, 2);
        chk("midrst_pre_pcm", strb_pcm[1], 2047);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("midrst_pcm", s_pcm, 0);
        chk("midrst_valid", int'(s_valid), 0);
        run_stream(0, 1, 193, 0);
        chk("midrst_first_idx", first_idx, 192);
        chk("midrst_hold", hold_bad, 0);
        chk("midrst_pcm_after", strb_pcm[0], 2047);

        // Decimation event coinciding with reset: reset wins, no strobe
        do_reset();
        run_stream(0, 1, 255, 0);
        chk("evrst_pre_strobes", n_strb, 1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("evrst_valid", int'(s_valid), 0);
        chk("evrst_pcm", s_pcm, 0);
        run_stream(0, 1, 193, 0);
        chk("evrst_first_idx", first_idx, 192);
        chk("evrst_ovl", strb_ovl[0], 1);

        // Long disable gap after a sample: output holds, no strobe
        do_reset();
        run_stream(1, 1, 193, 0);
        chk("gap_pre_pcm", strb_pcm[0], -2048);
        for (int g = 0; g < 20; g++) begin
            cyc(1'b0, 1'b0, 1'b1);
            chk($sformatf("gap_hold%0d", g), s_pcm + (s_valid ? 100000 : 0), -2048);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence needs roughly 6k cycles.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
